// File: rtl/gpio_pkg.sv
// Shared types and default sizes for the GPIO input conditioning slice.
package gpio_pkg;

  // Debounce FSM state for a single pin.
  typedef enum logic {
    FLT_IDLE,
    FLT_COUNT
  } flt_state_e;

  localparam int unsigned GPIO_SYNC_STAGES = 2;
  localparam int unsigned GPIO_FLT_CNT_W   = 8;

endpackage

// File: rtl/gpio_pin_filter.sv
// One GPIO pin: synchroniser chain, debounce FSM with saturating counter,
// and (with GPIO_IN_FILTER_IRQ_EN defined) edge detection feeding a pending flag.
module gpio_pin_filter
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int unsigned CNT_WIDTH   = GPIO_FLT_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 gpio_i,
  input  logic                 flt_en_i,
  input  logic [CNT_WIDTH-1:0] flt_thr_i,
  input  logic                 rise_en_i,
  input  logic                 fall_en_i,
  input  logic                 pend_clr_i,
  output logic                 data_o,
  output logic                 pend_o
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  flt_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   data_q, data_d;
  logic                   fast;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous pad value through the synchroniser chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
    end
  end

  // Debounce state, counter and filtered value registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FLT_IDLE;
      cnt_q   <= '0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Debounce next-state: unfiltered pins (or zero threshold) follow s directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fast    = !flt_en_i || (flt_thr_i == '0);
    unique case (state_q)
      FLT_IDLE: begin
        cnt_d = '0;
        if (s != data_q) begin
          if (fast) begin
            data_d = s;
          end else begin
            state_d = FLT_COUNT;
            cnt_d   = CntOne;
          end
        end
      end
      FLT_COUNT: begin
        if (s == data_q) begin
          // Glitch rejected.
          state_d = FLT_IDLE;
          cnt_d   = '0;
        end else if (fast || (cnt_q >= flt_thr_i)) begin
          data_d  = s;
          state_d = FLT_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = FLT_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_o = data_q;

`ifdef GPIO_IN_FILTER_IRQ_EN
  logic data_prev_q;
  logic pend_q;
  logic edge_set;

  assign edge_set = (rise_en_i & data_q & ~data_prev_q) |
                    (fall_en_i & ~data_q & data_prev_q);

  // Track the previous filtered value; a qualified edge sets pend and beats a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_prev_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      data_prev_q <= data_q;
      pend_q      <= edge_set | (pend_q & ~pend_clr_i);
    end
  end

  assign pend_o = pend_q;
`else
  logic unused_edge_cfg;
  assign unused_edge_cfg = rise_en_i ^ fall_en_i ^ pend_clr_i;
  assign pend_o          = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: per-pin sync + debounce (+ edge pending) and the
// combined interrupt register. Optional macro: GPIO_IN_FILTER_IRQ_EN enables
// edge detection, pend_o and irq_o; without it both outputs are tied to 0.
module gpio_in_filter
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_NUM    = 8,
  parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int unsigned CNT_WIDTH   = GPIO_FLT_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [GPIO_NUM-1:0]  gpio_i,
  input  logic [GPIO_NUM-1:0]  flt_en_i,
  input  logic [CNT_WIDTH-1:0] flt_thr_i,
  input  logic [GPIO_NUM-1:0]  rise_en_i,
  input  logic [GPIO_NUM-1:0]  fall_en_i,
  input  logic [GPIO_NUM-1:0]  int_en_i,
  input  logic [GPIO_NUM-1:0]  pend_clr_i,
  output logic [GPIO_NUM-1:0]  data_o,
  output logic [GPIO_NUM-1:0]  pend_o,
  output logic                 irq_o
);

  logic [GPIO_NUM-1:0] pin_pend;

  for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
    gpio_pin_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_pin (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .gpio_i    (gpio_i[g]),
      .flt_en_i  (flt_en_i[g]),
      .flt_thr_i (flt_thr_i),
      .rise_en_i (rise_en_i[g]),
      .fall_en_i (fall_en_i[g]),
      .pend_clr_i(pend_clr_i[g]),
      .data_o    (data_o[g]),
      .pend_o    (pin_pend[g])
    );
  end

  assign pend_o = pin_pend;

`ifdef GPIO_IN_FILTER_IRQ_EN
  logic irq_q;

  // Registered interrupt: lags pend_o by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(pin_pend & int_en_i);
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_int_en;
  assign unused_int_en = ^int_en_i;
  assign irq_o         = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// Self-checking bench for gpio_in_filter: directed scenarios followed by
// random stimulus, all compared against a run-length reference model.
module tb_gpio_in_filter;

`ifdef GPIO_IN_FILTER_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpio, flt_en, thr, rise_en, fall_en, int_en, pend_clr;
  logic [7:0] data_o, pend_o;
  logic       irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] m_data, m_prev, m_pend;
  logic       m_irq;
  int         run [8];
  logic [7:0] msync [$];

  gpio_in_filter dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .gpio_i    (gpio),
    .flt_en_i  (flt_en),
    .flt_thr_i (thr),
    .rise_en_i (rise_en),
    .fall_en_i (fall_en),
    .int_en_i  (int_en),
    .pend_clr_i(pend_clr),
    .data_o    (data_o),
    .pend_o    (pend_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0;
    m_prev = '0;
    m_pend = '0;
    m_irq  = 1'b0;
    for (int i = 0; i < 8; i++) run[i] = 0;
    msync.delete();
    msync.push_back(8'h00);
    msync.push_back(8'h00);
  endtask

  // A pin's filtered value follows s once s has differed for more than thr
  // consecutive samples, or immediately when unfiltered.
  task automatic model_edge();
    logic [7:0] s, nd, np, set;
    if (rst) begin
      model_reset();
    end else begin
      s  = msync[0];
      nd = m_data;
      set = (rise_en & m_data & ~m_prev) | (fall_en & ~m_data & m_prev);
      np = IRQ ? (set | (m_pend & ~pend_clr)) : 8'h00;
      m_irq = IRQ ? |(m_pend & int_en) : 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (s[i] == m_data[i]) begin
          run[i] = 0;
        end else begin
          run[i]++;
          if (!flt_en[i] || thr == 0 || run[i] > int'(thr)) begin
            nd[i]  = s[i];
            run[i] = 0;
          end
        end
      end
      m_prev = m_data;
      m_data = nd;
      m_pend = np;
      msync.push_back(gpio);
      void'(msync.pop_front());
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("data_model", data_o, m_data);
      chk("pend_model", pend_o, m_pend);
      chk("irq_model", irq_o, m_irq);
    end
  endtask

  initial begin
    rst = 1'b1; gpio = 8'hA5; flt_en = '0; thr = '0;
    rise_en = '0; fall_en = '0; int_en = '0; pend_clr = '0;
    model_reset();

    // Reset with pad pattern held.
    tick(3);
    chk("reset_data", data_o, 8'h00);
    chk("reset_pend", pend_o, 8'h00);
    chk("reset_irq", irq_o, 1'b0);
    rst = 1'b0;
    tick(2);
    chk("rel_data_2", data_o, 8'h00);
    tick(1);
    chk("rel_data_3", data_o, 8'hA5);

    // Debounce: short pulse rejected, held level accepted after 7 edges.
    gpio = 8'h00;
    tick(4);
    flt_en[0] = 1'b1; thr = 8'd4;
    gpio[0] = 1'b1;
    tick(3);
    gpio[0] = 1'b0;
    tick(10);
    chk("pulse_reject", data_o[0], 1'b0);
    gpio[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      chk("deb_latency", data_o[0], (i == 7));
    end

    // Rising edge -> pend -> irq -> clear.
    rise_en[1] = 1'b1; int_en[1] = 1'b1;
    gpio[1] = 1'b1;
    tick(3);
    chk("edge_data", data_o[1], 1'b1);
    chk("edge_pend_early", pend_o[1], 1'b0);
    tick(1);
    chk("edge_pend", pend_o[1], IRQ);
    chk("edge_irq_early", irq_o, 1'b0);
    tick(1);
    chk("edge_irq", irq_o, IRQ);
    pend_clr[1] = 1'b1;
    tick(1);
    pend_clr[1] = 1'b0;
    chk("clr_pend", pend_o[1], 1'b0);
    chk("clr_irq_lag", irq_o, IRQ);
    tick(1);
    chk("clr_irq", irq_o, 1'b0);

    // Set/clear collision on a qualified fall.
    fall_en[2] = 1'b1;
    gpio[2] = 1'b1;
    tick(4);
    gpio[2] = 1'b0;
    tick(3);
    pend_clr[2] = 1'b1;
    tick(1);
    pend_clr[2] = 1'b0;
    chk("collide_pend", pend_o[2], IRQ);
    pend_clr[2] = 1'b1;
    tick(1);
    pend_clr[2] = 1'b0;

    // Threshold lowered mid-count.
    flt_en[4] = 1'b1; thr = 8'd200;
    gpio[4] = 1'b1;
    tick(52);
    chk("thr_hold", data_o[4], 1'b0);
    thr = 8'd10;
    tick(1);
    chk("thr_lower", data_o[4], 1'b1);

    // Async reset while pin3 is counting.
    thr = 8'd20; flt_en[3] = 1'b1; rise_en[3] = 1'b1;
    gpio[3] = 1'b1;
    tick(10);
    #2 rst = 1'b1;
    #1 model_reset();
    chk("async_data", data_o, 8'h00);
    chk("async_pend", pend_o, 8'h00);
    chk("async_irq", irq_o, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(22);
    chk("restart_hold", data_o[3], 1'b0);
    tick(1);
    chk("restart_done", data_o[3], 1'b1);

    // Random stimulus against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) gpio = gpio ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) thr = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) flt_en = 8'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        rise_en = 8'($urandom);
        fall_en = 8'($urandom);
        int_en  = 8'($urandom);
      end
      pend_clr = 8'($urandom) & 8'($urandom) & 8'($urandom);
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
